instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch unit for the RISC-V core: the initiator on the instruction-memory read port. Owns the program counter and drives the fetch address into the combinational instruction memory. Registers the returned word into a one-entry fetch buffer and hands it to decode over a valid/ready handshake. Handles branch/jump redirects and flags illegal fetch addresses (misaligned or beyond memory).

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 1024, instruction memory size in bytes; must be a multiple of 4 and ≥ 4.

Ports:
- I_clk  input  1  clock; all state updates on the rising edge.
- I_rstn  input  1  reset; asynchronous, active-low.
- O_imem_address  output  32  byte address to instruction memory; equals the PC register (combinational from it).
- I_imem_data  input  32  little-endian word returned combinationally for O_imem_address.
- I_redirect  input  1  branch/jump taken; load new PC and flush.
- I_redirect_pc  input  32  target PC, sampled when I_redirect=1.
- O_valid  output  1  fetch buffer holds an instruction for decode.
- O_instr  output  32  buffered instruction word.
- O_pc  output  32  address of O_instr.
- I_ready  input  1  decode accepts O_instr this cycle when O_valid=1.
- O_fault  output  1  fetch halted on an illegal PC.
- O_fetch_pc  output  32  current PC register (the faulting address while O_fault=1).

## Operation

- State machine, two states: RUN, FAULT. O_fault = (state==FAULT).
- legal(pc) = pc[1:0]==2'b00 and pc ≤ MEM_BYTES−4; compare at 33 bits so no wrap occurs.
- load = !O_valid || I_ready (buffer is empty or being drained).
- Priority per cycle, highest first:
  - I_redirect=1:
    - PC ← I_redirect_pc; O_valid ← 0 (an instruction in the buffer is discarded even if I_ready=1 that cycle); state ← RUN.
    - I_imem_data is ignored that cycle.
    - Legality of the new PC is checked on the next fetch.
  - state RUN, load=1, legal(PC):
    - O_instr ← I_imem_data; O_pc ← PC; O_valid ← 1; PC ← PC+4 (mod 2^32).
  - state RUN, load=1, !legal(PC):
    - state ← FAULT; O_valid ← 0; PC holds.
  - state RUN, load=0 (stall: O_valid=1, I_ready=0):
    - PC, O_instr, O_pc, O_valid all hold.
  - state FAULT, no redirect:
    - everything holds; O_valid stays 0.
    - Only I_redirect or reset exits FAULT.
- A word is transferred to decode on each edge where O_valid && I_ready. Each fetched word is delivered exactly once, in PC order, with no duplicates or gaps between redirects.
- O_instr/O_pc are don't-care while O_valid=0 but must not change while O_valid=1 && I_ready=0.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert via I_clk), all state immediately:
  - PC=RESET_PC, so O_imem_address=O_fetch_pc=RESET_PC.
  - O_valid=0, O_instr=0, O_pc=0, state=RUN, O_fault=0.
- Reset asserted mid-stream returns all state to reset values at once; no partial instruction survives.
- Fetch latency: address X on O_imem_address in cycle n → O_instr=mem[X], O_pc=X, O_valid=1 in cycle n+1.
- Throughput: 1 instruction/cycle with I_ready held high.
- Redirect penalty: redirect in cycle n → O_valid=0 in n+1, target instruction valid in n+2.
- Fault: illegal PC at a load edge → O_fault=1 from the next cycle; O_valid=0 from the same edge.
- Back-to-back redirects: the last one wins; each one flushes.
- Redirect and I_ready both high in the same cycle: the handshake completes for decode, but fetch still takes the redirect.

## Test plan

- Reset stream:
  - Stimulus: memory words 0x00000013, 0x00100093, 0x00200113…; RESET_PC=0; I_ready=1.
  - Required: O_pc=0,4,8… on consecutive cycles from the 1st cycle after reset release; O_instr matches each word; O_fault=0.
- Backpressure:
  - Stimulus: I_ready=0 for 3 cycles while O_valid=1 at O_pc=8.
  - Required: O_instr/O_pc hold at 8; O_fetch_pc holds at 12; on I_ready=1, O_pc=8 transfers once, then 12 follows with no duplicate or skip.
- Redirect:
  - Stimulus: I_redirect=1, I_redirect_pc=0x40 while O_valid=1, I_ready=0.
  - Required: buffer flushed (O_valid=0 next cycle); O_pc=0x40 valid the following cycle; instruction after the old PC never delivered.
- Misaligned fault and recovery:
  - Stimulus: redirect to 0x42.
  - Required: O_fault=1 and O_fetch_pc=0x42 two cycles later, O_valid stays 0.
  - Stimulus: redirect to 0x10.
  - Required: O_fault=0 next cycle; O_pc=0x10 valid one cycle after that.
- End of memory:
  - Stimulus: MEM_BYTES=1024, redirect to 0x3F8.
  - Required: 0x3F8 and 0x3FC delivered; PC=0x400 then faults, O_fault=1, O_fetch_pc=0x400.
- Reset mid-operation:
  - Stimulus: assert I_rstn=0 between clock edges while O_valid=1 and O_fault=0.
  - Required: O_valid=0 and O_imem_address=RESET_PC immediately, without waiting for a clock edge; normal stream resumes after release.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port plus the fetch-to-decode handshake and redirect/fault sideband.
// The fetch unit uses the master view; memory/decode/branch logic sees the slave view.
interface instruction_fetch_if;
    logic [31:0] O_imem_address;
    logic [31:0] I_imem_data;
    logic        I_redirect;
    logic [31:0] I_redirect_pc;
    logic        O_valid;
    logic [31:0] O_instr;
    logic [31:0] O_pc;
    logic        I_ready;
    logic        O_fault;
    logic [31:0] O_fetch_pc;

    modport master (
        output O_imem_address,
        input  I_imem_data,
        input  I_redirect,
        input  I_redirect_pc,
        output O_valid,
        output O_instr,
        output O_pc,
        input  I_ready,
        output O_fault,
        output O_fetch_pc
    );

    modport slave (
        input  O_imem_address,
        output I_imem_data,
        output I_redirect,
        output I_redirect_pc,
        input  O_valid,
        input  O_instr,
        input  O_pc,
        output I_ready,
        input  O_fault,
        input  O_fetch_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads a combinational instruction memory into a one-entry
// buffer handed to decode over valid/ready, with redirect flush and illegal-PC halt.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
) (
    input  logic                  I_clk,
    input  logic                  I_rstn,
    instruction_fetch_if.master   bus
);

    typedef enum logic {RUN, FAULT} state_t;

    // Highest legal word address, widened so the compare cannot wrap.
    localparam logic [32:0] LAST_WORD = 33'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        load;

    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && ({1'b0, pc} <= LAST_WORD);
    endfunction

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        load    = !valid_q || bus.I_ready;

        // A redirect discards the buffer even when decode is taking it this cycle.
        if (bus.I_redirect) begin
            pc_d    = bus.I_redirect_pc;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN && load) begin
            if (pc_legal(pc_q)) begin
                instr_d = bus.I_imem_data;
                opc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end else begin
                state_d = FAULT;
                valid_d = 1'b0;
            end
        end
    end

    assign bus.O_imem_address = pc_q;
    assign bus.O_fetch_pc     = pc_q;
    assign bus.O_valid        = valid_q;
    assign bus.O_instr        = instr_q;
    assign bus.O_pc           = opc_q;
    assign bus.O_fault        = (state_q == FAULT);

endmodule
